// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pic_pkg
// Description : Shared defaults and trigger-mode encoding for the PIC
//               interrupt request register slice.
//               Contents:
//                 c_NUM_IR_DEFAULT      - default number of request channels
//                 c_SYNC_STAGES_DEFAULT - default synchroniser depth
//                 trig_mode_e           - per-channel trigger mode encoding
//                 isLevelMode()         - decode helper for one levelMode bit
// Revision    : 1.0 - initial release
// ============================================================================
package pic_pkg;

    localparam int c_NUM_IR_DEFAULT      = 8;
    localparam int c_SYNC_STAGES_DEFAULT = 2;

    // One bit per channel on the levelMode bus.
    typedef enum logic {
        TRIG_EDGE  = 1'b0,
        TRIG_LEVEL = 1'b1
    } trig_mode_e;

    function automatic logic isLevelMode(input logic modeBit);
        return (trig_mode_e'(modeBit) == TRIG_LEVEL);
    endfunction

endpackage : pic_pkg
`default_nettype wire

// File: rtl/pic_request_register_if.sv
`default_nettype none
// ============================================================================
// Module      : pic_request_register_if
// Description : Control-side handshake bundle of the interrupt request
//               register: the serviced-bit clear handshake and the IRR
//               read-back path.
//               Signals:
//                 clrValid  - request to clear one IRR bit       (master -> slave)
//                 clrIdx    - channel index to clear             (master -> slave)
//                 clrAck    - one-cycle acknowledge of a clear   (slave -> master)
//                 readIrr   - request an IRR snapshot            (master -> slave)
//                 dataOut   - registered IRR snapshot            (slave -> master)
//                 dataValid - one-cycle strobe, dataOut valid    (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface pic_request_register_if
    import pic_pkg::*;
#(
    parameter int NUM_IR = c_NUM_IR_DEFAULT,
    parameter int IDX_W  = $clog2(NUM_IR)
);

    logic              clrValid;
    logic [IDX_W-1:0]  clrIdx;
    logic              clrAck;
    logic              readIrr;
    logic [NUM_IR-1:0] dataOut;
    logic              dataValid;

    // Control logic / priority resolver side.
    modport master (
        output clrValid,
        output clrIdx,
        output readIrr,
        input  clrAck,
        input  dataOut,
        input  dataValid
    );

    // Request register side.
    modport slave (
        input  clrValid,
        input  clrIdx,
        input  readIrr,
        output clrAck,
        output dataOut,
        output dataValid
    );

endinterface : pic_request_register_if
`default_nettype wire

// File: rtl/pic_sync_bit.sv
`default_nettype none
// ============================================================================
// Module      : pic_sync_bit
// Description : Single-bit flop-chain synchroniser for one raw interrupt
//               request pin. All flops clear asynchronously on reset.
//               Ports:
//                 clk       - destination clock
//                 rst_n     - asynchronous active-low reset
//                 i_asyncIn - raw asynchronous input
//                 o_syncOut - synchronised output (last flop of the chain)
// Revision    : 1.0 - initial release
// ============================================================================
module pic_sync_bit
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = c_SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_asyncIn,
    output logic o_syncOut
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_asyncIn};
        end
    end

    assign o_syncOut = r_chain[SYNC_STAGES-1];

endmodule : pic_sync_bit
`default_nettype wire

// File: rtl/pic_request_register.sv
`default_nettype none
// ============================================================================
// Module      : pic_request_register
// Description : Interrupt Request Register (IRR) of a PIC. Synchronises the
//               raw request pins, detects rising edges or follows levels per
//               channel, holds its contents while the INTA sequence freezes
//               it (edges arriving meanwhile are parked in a shadow register)
//               and supports single-bit clears plus snapshot read-back.
//               Ports:
//                 clk         - single clock, rising edge
//                 rst_n       - asynchronous active-low reset
//                 irIn        - raw asynchronous request pins
//                 levelMode   - per channel: 1 = level, 0 = rising edge
//                 imr         - per channel mask, 1 = masked
//                 freeze      - hold IRR (clears still allowed)
//                 bus         - clear handshake and read-back (slave side)
//                 irr         - current IRR contents (registered)
//                 unmaskedReq - irr & ~imr (combinational)
//                 intReq      - registered OR of unmaskedReq
// Revision    : 1.0 - initial release
// ============================================================================
module pic_request_register
    import pic_pkg::*;
#(
    parameter int NUM_IR      = c_NUM_IR_DEFAULT,
    parameter int SYNC_STAGES = c_SYNC_STAGES_DEFAULT,
    parameter int IDX_W       = $clog2(NUM_IR)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_IR-1:0]    irIn,
    input  logic [NUM_IR-1:0]    levelMode,
    input  logic [NUM_IR-1:0]    imr,
    input  logic                 freeze,
    pic_request_register_if.slave bus,
    output logic [NUM_IR-1:0]    irr,
    output logic [NUM_IR-1:0]    unmaskedReq,
    output logic                 intReq
);

    // Number of clock edges after reset release before edge detection is
    // trusted: the synchroniser must fill and prevIr must catch up once, so
    // a pin already high at release is never mistaken for a fresh edge.
    localparam int c_FILL   = SYNC_STAGES + 1;
    localparam int c_FILL_W = $clog2(c_FILL + 1);

    logic [NUM_IR-1:0] w_syncIr;
    logic [NUM_IR-1:0] w_isLevel;
    logic [NUM_IR-1:0] r_prevIr;
    logic [NUM_IR-1:0] r_edgePend;
    logic [NUM_IR-1:0] r_levelModeQ;
    logic [NUM_IR-1:0] w_rise;
    logic [NUM_IR-1:0] w_modeChg;
    logic [NUM_IR-1:0] w_clrMask;
    logic [NUM_IR-1:0] w_kill;
    logic [NUM_IR-1:0] w_irrNext;
    logic [NUM_IR-1:0] w_pendNext;
    logic [NUM_IR-1:0] r_dataOut;
    logic              r_dataValid;
    logic              r_clrAck;
    logic [c_FILL_W-1:0] r_fillCnt;
    logic              w_armed;
    logic [IDX_W-1:0]  w_clrIdx;
    logic [31:0]       w_clrIdxExt;
    logic              w_clrHit;

    // ------------------------------------------------------------------
    // Per-channel synchroniser and trigger-mode decode
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_IR; gi++) begin : g_chan
        pic_sync_bit #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_asyncIn (irIn[gi]),
            .o_syncOut (w_syncIr[gi])
        );

        assign w_isLevel[gi] = isLevelMode(levelMode[gi]);
    end

    // ------------------------------------------------------------------
    // Post-reset arming counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fillCnt <= '0;
        end else if (!w_armed) begin
            r_fillCnt <= r_fillCnt + 1'b1;
        end
    end

    assign w_armed = (r_fillCnt == c_FILL_W'(c_FILL));

    // Rising edge of the synchronised pin, suppressed until armed.
    assign w_rise = w_syncIr & ~r_prevIr & {NUM_IR{w_armed}};

    // ------------------------------------------------------------------
    // Clear decode: out-of-range indices are simply ignored.
    // ------------------------------------------------------------------
    assign w_clrIdx    = bus.clrIdx;
    assign w_clrIdxExt = 32'(w_clrIdx);
    assign w_clrHit    = bus.clrValid && (w_clrIdxExt < 32'(NUM_IR));
    assign w_clrMask   = w_clrHit ? ({{(NUM_IR-1){1'b0}}, 1'b1} << w_clrIdx)
                                  : '0;

    // A trigger-mode change restarts the channel from a clean state.
    assign w_modeChg = levelMode ^ r_levelModeQ;

    // Clear and mode change beat any set arriving in the same cycle.
    assign w_kill = w_clrMask | w_modeChg;

    // ------------------------------------------------------------------
    // IRR / shadow next-state
    // ------------------------------------------------------------------
    always_comb begin
        w_irrNext  = irr;
        w_pendNext = r_edgePend;

        if (freeze) begin
            // IRR holds; edge-channel rises are parked for later.
            w_pendNext = r_edgePend | (w_rise & ~w_isLevel);
        end else begin
            // Level channels track the pin; edge channels latch new rises
            // plus anything parked during the previous freeze.
            w_irrNext  = (w_isLevel  & w_syncIr)
                       | (~w_isLevel & (irr | w_rise | r_edgePend));
            w_pendNext = '0;
        end

        w_irrNext  = w_irrNext  & ~w_kill;
        w_pendNext = w_pendNext & ~w_kill;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prevIr     <= '0;
            r_edgePend   <= '0;
            r_levelModeQ <= '0;
            irr          <= '0;
            intReq       <= 1'b0;
            r_clrAck     <= 1'b0;
        end else begin
            r_prevIr     <= w_syncIr;
            r_edgePend   <= w_pendNext;
            r_levelModeQ <= levelMode;
            irr          <= w_irrNext;
            intReq       <= |unmaskedReq;
            r_clrAck     <= w_clrHit;
        end
    end

    // Snapshot uses the IRR value before this cycle's update, so a clear
    // issued alongside the read still shows the bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dataOut   <= '0;
            r_dataValid <= 1'b0;
        end else begin
            r_dataValid <= bus.readIrr;
            if (bus.readIrr) begin
                r_dataOut <= irr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign unmaskedReq   = irr & ~imr;
    assign bus.clrAck    = r_clrAck;
    assign bus.dataOut   = r_dataOut;
    assign bus.dataValid = r_dataValid;

endmodule : pic_request_register
`default_nettype wire

// File: tb/tb_pic_request_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_pic_request_register
// Description : Self-checking bench for pic_request_register. Directed
//               scenarios with literal expectations followed by a random
//               phase; every cycle the outputs are compared against a
//               behavioural channel-by-channel model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pic_request_register;
    import pic_pkg::*;

    localparam int c_NUM_IR      = 8;
    localparam int c_SYNC_STAGES = 2;
    localparam int c_IDX_W       = 4;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b1;
    logic [c_NUM_IR-1:0] irIn      = '0;
    logic [c_NUM_IR-1:0] levelMode = '0;
    logic [c_NUM_IR-1:0] imr       = '0;
    logic                freeze    = 1'b0;
    logic [c_NUM_IR-1:0] irr;
    logic [c_NUM_IR-1:0] unmaskedReq;
    logic                intReq;

    int nCmp = 0;
    int nErr = 0;
    bit checkEn = 1'b0;

    pic_request_register_if #(.NUM_IR(c_NUM_IR), .IDX_W(c_IDX_W)) bus ();

    pic_request_register #(
        .NUM_IR      (c_NUM_IR),
        .SYNC_STAGES (c_SYNC_STAGES),
        .IDX_W       (c_IDX_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irIn        (irIn),
        .levelMode   (levelMode),
        .imr         (imr),
        .freeze      (freeze),
        .bus         (bus),
        .irr         (irr),
        .unmaskedReq (unmaskedReq),
        .intReq      (intReq)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: pin delayed by the synchroniser depth, then the
    // per-channel rules for edge/level, freeze, clear and mode change.
    // ------------------------------------------------------------------
    logic [c_NUM_IR-1:0] mHist [c_SYNC_STAGES];
    logic [c_NUM_IR-1:0] mPrev, mPend, mIrr, mDataOut, mMode;
    logic [c_NUM_IR-1:0] mS, mNIrr, mNPend;
    logic                mDataValid, mClrAck, mIntReq;
    int                  mSince;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < c_SYNC_STAGES; i++) mHist[i] = '0;
            mPrev = '0; mPend = '0; mIrr = '0; mDataOut = '0; mMode = '0;
            mDataValid = 1'b0; mClrAck = 1'b0; mIntReq = 1'b0;
            mSince = 0;
        end else begin
            mS = mHist[c_SYNC_STAGES-1];
            for (int c = 0; c < c_NUM_IR; c++) begin
                bit lvl, rise, kill;
                lvl  = levelMode[c];
                rise = mS[c] && !mPrev[c] && (mSince >= c_SYNC_STAGES + 1);
                kill = (bus.clrValid && (int'(bus.clrIdx) == c)) || (levelMode[c] != mMode[c]);
                if (kill) begin
                    mNIrr[c] = 1'b0; mNPend[c] = 1'b0;
                end else if (freeze) begin
                    mNIrr[c] = mIrr[c]; mNPend[c] = mPend[c] || (rise && !lvl);
                end else if (lvl) begin
                    mNIrr[c] = mS[c]; mNPend[c] = 1'b0;
                end else begin
                    mNIrr[c] = mIrr[c] || rise || mPend[c]; mNPend[c] = 1'b0;
                end
            end
            mDataValid = bus.readIrr;
            if (bus.readIrr) mDataOut = mIrr;
            mClrAck = bus.clrValid && (int'(bus.clrIdx) < c_NUM_IR);
            mIntReq = |(mIrr & ~imr);
            mIrr  = mNIrr;
            mPend = mNPend;
            mPrev = mS;
            mMode = levelMode;
            for (int i = c_SYNC_STAGES - 1; i > 0; i--) mHist[i] = mHist[i-1];
            mHist[0] = irIn;
            if (mSince < 1000) mSince++;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            if (!rst_n) begin
                cmp("rst_irr",       32'(irr),           32'(0));
                cmp("rst_unmasked",  32'(unmaskedReq),   32'(0));
                cmp("rst_intReq",    32'(intReq),        32'(0));
                cmp("rst_clrAck",    32'(bus.clrAck),    32'(0));
                cmp("rst_dataValid", 32'(bus.dataValid), 32'(0));
                cmp("rst_dataOut",   32'(bus.dataOut),   32'(0));
            end else begin
                cmp("mdl_irr",       32'(irr),           32'(mIrr));
                cmp("mdl_unmasked",  32'(unmaskedReq),   32'(mIrr & ~imr));
                cmp("mdl_intReq",    32'(intReq),        32'(mIntReq));
                cmp("mdl_clrAck",    32'(bus.clrAck),    32'(mClrAck));
                cmp("mdl_dataValid", 32'(bus.dataValid), 32'(mDataValid));
                cmp("mdl_dataOut",   32'(bus.dataOut),   32'(mDataOut));
            end
        end
    end

    // Advance n rising edges, then move just past the edge to drive inputs.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.clrValid = 1'b0;
        bus.clrIdx   = '0;
        bus.readIrr  = 1'b0;
        #1 rst_n = 1'b0;
        checkEn = 1'b1;

        // Reset state
        step(2);
        @(negedge clk);
        cmp("reset_irr",       32'(irr),           32'h0);
        cmp("reset_intReq",    32'(intReq),        32'h0);
        cmp("reset_dataValid", 32'(bus.dataValid), 32'h0);
        step(1); rst_n = 1'b1;
        step(6);

        // Edge channel 3: set latency, intReq, clear, no re-trigger
        irIn = 8'h08;
        step(2); @(negedge clk); cmp("edge_not_yet", 32'(irr), 32'h00);
        step(1); @(negedge clk); cmp("edge_set", 32'(irr), 32'h08);
        cmp("edge_intReq_lag", 32'(intReq), 32'h0);
        step(1); bus.clrValid = 1'b1; bus.clrIdx = 4'd3;
        @(negedge clk); cmp("edge_intReq", 32'(intReq), 32'h1);
        step(1); bus.clrValid = 1'b0;
        @(negedge clk); cmp("clr3_irr", 32'(irr), 32'h00);
        cmp("clr3_ack", 32'(bus.clrAck), 32'h1);
        step(2); @(negedge clk); cmp("clr3_held_low", 32'(irr), 32'h00);
        cmp("clr3_ack_once", 32'(bus.clrAck), 32'h0);

        // Level channel 5, masked
        step(1); irIn = 8'h00; levelMode = 8'h20; imr = 8'h20;
        step(1); irIn = 8'h20;
        step(3); @(negedge clk); cmp("lvl_irr", 32'(irr), 32'h20);
        cmp("lvl_unmasked", 32'(unmaskedReq), 32'h00);
        step(1); @(negedge clk); cmp("lvl_intReq", 32'(intReq), 32'h0);
        step(1); irIn = 8'h00;
        step(2); @(negedge clk); cmp("lvl_hold", 32'(irr), 32'h20);
        step(1); @(negedge clk); cmp("lvl_drop", 32'(irr), 32'h00);

        // Freeze: edge on channel 1 parked, released on unfreeze
        step(1); levelMode = 8'h00; imr = 8'h00; freeze = 1'b1;
        step(1); irIn = 8'h02;
        step(4); @(negedge clk); cmp("frz_hold", 32'(irr), 32'h00);
        step(1); freeze = 1'b0;
        @(negedge clk); cmp("frz_still", 32'(irr), 32'h00);
        step(1); @(negedge clk); cmp("frz_release", 32'(irr), 32'h02);

        // Clear beats same-cycle edge on channel 2
        step(1); bus.clrValid = 1'b1; bus.clrIdx = 4'd1;
        step(1); bus.clrValid = 1'b0; irIn = 8'h06;
        @(negedge clk); cmp("clr1_irr", 32'(irr), 32'h00);
        step(2); bus.clrValid = 1'b1; bus.clrIdx = 4'd2;
        step(1); bus.clrValid = 1'b0;
        @(negedge clk); cmp("clr_beats_set", 32'(irr), 32'h00);
        cmp("clr2_ack", 32'(bus.clrAck), 32'h1);
        step(2); @(negedge clk); cmp("edge_lost", 32'(irr), 32'h00);

        // Out-of-range clear, then read with simultaneous clear
        step(1); irIn = 8'h87;
        step(3); @(negedge clk); cmp("irr_81", 32'(irr), 32'h81);
        step(1); bus.clrValid = 1'b1; bus.clrIdx = 4'd9;
        step(1); bus.clrValid = 1'b0;
        @(negedge clk); cmp("clr9_irr", 32'(irr), 32'h81);
        cmp("clr9_noack", 32'(bus.clrAck), 32'h0);
        step(1); bus.readIrr = 1'b1; bus.clrValid = 1'b1; bus.clrIdx = 4'd7;
        step(1); bus.readIrr = 1'b0; bus.clrValid = 1'b0;
        @(negedge clk); cmp("rd_data", 32'(bus.dataOut), 32'h81);
        cmp("rd_valid", 32'(bus.dataValid), 32'h1);
        cmp("rd_irr_after", 32'(irr), 32'h01);
        step(1); @(negedge clk); cmp("rd_valid_pulse", 32'(bus.dataValid), 32'h0);
        cmp("rd_data_hold", 32'(bus.dataOut), 32'h81);

        // Reset during freeze with a parked edge; pin high at release
        step(1); irIn = 8'h00; freeze = 1'b1;
        step(3); irIn = 8'h04;
        step(4); @(negedge clk); cmp("frz2_hold", 32'(irr), 32'h01);
        step(1); rst_n = 1'b0;
        @(negedge clk); cmp("rst_mid_irr", 32'(irr), 32'h00);
        step(2); rst_n = 1'b1; freeze = 1'b0;
        step(8); @(negedge clk); cmp("no_edge_after_rst", 32'(irr), 32'h00);

        // Random phase
        begin
            int rstHold;
            int b;
            rstHold = 0;
            step(1); irIn = 8'h00;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                step(1);
                if (rstHold > 0) begin
                    rstHold--;
                    if (rstHold == 0) rst_n = 1'b1;
                end else if ($urandom_range(0, 599) == 0) begin
                    rst_n = 1'b0;
                    rstHold = 2;
                end
                for (int k = 0; k < c_NUM_IR; k++) begin
                    if ($urandom_range(0, 7) == 0) irIn[k] = ~irIn[k];
                end
                if ($urandom_range(0, 39) == 0) begin
                    b = $urandom_range(0, c_NUM_IR - 1);
                    levelMode[b] = ~levelMode[b];
                end
                if ($urandom_range(0, 15) == 0) imr = 8'($urandom);
                if ($urandom_range(0, 9) == 0) freeze = ~freeze;
                bus.clrValid = ($urandom_range(0, 3) == 0);
                bus.clrIdx   = 4'($urandom_range(0, 10));
                bus.readIrr  = ($urandom_range(0, 4) == 0);
            end
        end

        step(2);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule : tb_pic_request_register
`default_nettype wire
